pid_loop_ctrl: RTL and testbench

Sequencer for one closed-loop PID iteration of the supply controller. Each `sample_tick` triggers an ADC conversion and computes the error terms. It then runs the `pid_sum` datapath through its `sum_en`/`sum_rdy` handshake and converts the signed sum into a clamped PWM duty word. It sits between the ADC interface, the `pid_sum` instance and the PWM generator, and owns the error history, the integral accumulator and anti-windup.

---
 rtl/pid_loop_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pid_loop_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_loop_ctrl.sv
// pid_loop_ctrl: runs one PID iteration per sample_tick (ADC capture, error terms, pid_sum, duty clamp).
// Every output is a register, so no input reaches an output in the same cycle.
`timescale 1ns/1ps
module pid_loop_ctrl #(
   parameter int ADC_WIDTH   = 13,
   parameter int DUTY_WIDTH  = 10,
   parameter int OUT_SHIFT   = 10,
   parameter int ADC_TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          enable,
   input  logic                          sample_tick,
   input  logic [ADC_WIDTH-1:0]          setpoint,
   output logic                          adc_start,
   input  logic                          adc_valid,
   input  logic [ADC_WIDTH-1:0]          adc_data,
   output logic signed [ADC_WIDTH-1:0]   proportional,
   output logic signed [ADC_WIDTH-1:0]   derivative,
   output logic signed [2*ADC_WIDTH-1:0] integral,
   output logic                          sum_en,
   input  logic                          sum_rdy,
   input  logic signed [3*ADC_WIDTH:0]   sum,
   output logic [DUTY_WIDTH-1:0]         duty,
   output logic                          duty_valid,
   output logic                          overrun,
   output logic                          adc_fault
);
   localparam int W     = ADC_WIDTH;
   localparam int SW    = 3*W+1;
   localparam int CNT_W = $clog2(ADC_TIMEOUT+1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADC_TIMEOUT-1);
   localparam logic signed [W:0]    E_MAX = {2'b00, {(W-1){1'b1}}};
   localparam logic signed [W:0]    E_MIN = -E_MAX;
   localparam logic signed [2*W:0]  I_MAX = {2'b00, {(2*W-1){1'b1}}};
   localparam logic signed [2*W:0]  I_MIN = -I_MAX;
   localparam logic signed [SW-1:0] DUTY_MAX = {{(SW-DUTY_WIDTH){1'b0}}, {DUTY_WIDTH{1'b1}}};

   typedef enum logic [2:0] {
      IDLE, ADC_REQ, ADC_WAIT, CALC, INTEG, SUM_START, SUM_ARM, SUM_WAIT
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [W-1:0]           sample_q, sample_d;
   logic signed [W-1:0]    prop_q, prop_d;
   logic signed [W-1:0]    deriv_q, deriv_d;
   logic signed [2*W-1:0]  integ_q, integ_d;
   logic [DUTY_WIDTH-1:0]  duty_q, duty_d;
   logic                   adc_start_q, adc_start_d;
   logic                   sum_en_q, sum_en_d;
   logic                   duty_valid_q, duty_valid_d;
   logic                   overrun_q, overrun_d;
   logic                   adc_fault_q, adc_fault_d;

   function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] x);
      if (x > E_MAX)      sat_w = E_MAX[W-1:0];
      else if (x < E_MIN) sat_w = E_MIN[W-1:0];
      else                sat_w = x[W-1:0];
   endfunction

   function automatic logic signed [2*W-1:0] sat_2w(input logic signed [2*W:0] x);
      if (x > I_MAX)      sat_2w = I_MAX[2*W-1:0];
      else if (x < I_MIN) sat_2w = I_MIN[2*W-1:0];
      else                sat_2w = x[2*W-1:0];
   endfunction

   // prop_q always holds the latest error, so it doubles as e_prev.
   logic signed [W:0]     e_raw, d_raw;
   logic signed [W-1:0]   e_sat;
   logic signed [2*W:0]   i_raw;
   logic signed [SW-1:0]  shifted;
   logic [DUTY_WIDTH-1:0] duty_clamp;
   logic                  windup_hold;

   assign e_raw   = $signed({1'b0, setpoint}) - $signed({1'b0, sample_q});
   assign e_sat   = sat_w(e_raw);
   assign d_raw   = $signed({e_sat[W-1], e_sat}) - $signed({prop_q[W-1], prop_q});
   assign i_raw   = $signed({integ_q[2*W-1], integ_q})
                  + $signed({{(W+1){prop_q[W-1]}}, prop_q});
   assign shifted = sum >>> OUT_SHIFT;
   assign windup_hold = ((duty_q == '0) && prop_q[W-1])
                     || ((duty_q == '1) && !prop_q[W-1] && (prop_q != '0));

   always_comb begin
      if (shifted[SW-1])          duty_clamp = '0;
      else if (shifted > DUTY_MAX) duty_clamp = '1;
      else                        duty_clamp = shifted[DUTY_WIDTH-1:0];
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sample_d     = sample_q;
      prop_d       = prop_q;
      deriv_d      = deriv_q;
      integ_d      = integ_q;
      duty_d       = duty_q;
      adc_start_d  = 1'b0;
      sum_en_d     = 1'b0;
      duty_valid_d = 1'b0;
      adc_fault_d  = 1'b0;
      overrun_d    = sample_tick && ((state_q != IDLE) || !sum_rdy);

      case (state_q)
         IDLE: begin
            if (sample_tick && enable && sum_rdy) begin
               state_d     = ADC_REQ;
               adc_start_d = 1'b1;
            end
         end
         ADC_REQ: begin
            state_d = ADC_WAIT;
            cnt_d   = '0;
         end
         ADC_WAIT: begin
            if (adc_valid) begin
               sample_d = adc_data;
               state_d  = CALC;
            end else if (cnt_q == CNT_LAST) begin
               adc_fault_d = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CALC: begin
            prop_d  = e_sat;
            deriv_d = sat_w(d_raw);
            state_d = INTEG;
         end
         INTEG: begin
            if (!windup_hold) integ_d = sat_2w(i_raw);
            sum_en_d = 1'b1;
            state_d  = SUM_START;
         end
         SUM_START: state_d = SUM_ARM;
         SUM_ARM: begin
            if (!sum_rdy) state_d = SUM_WAIT;
         end
         SUM_WAIT: begin
            if (sum_rdy) begin
               duty_d       = duty_clamp;
               duty_valid_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Disable abandons any pid_sum in flight; IDLE waits for sum_rdy before the next start.
      if (!enable) begin
         state_d      = IDLE;
         adc_start_d  = 1'b0;
         sum_en_d     = 1'b0;
         duty_valid_d = (duty_q != '0);
         duty_d       = '0;
         prop_d       = '0;
         deriv_d      = '0;
         integ_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sample_q     <= '0;
         prop_q       <= '0;
         deriv_q      <= '0;
         integ_q      <= '0;
         duty_q       <= '0;
         adc_start_q  <= 1'b0;
         sum_en_q     <= 1'b0;
         duty_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         adc_fault_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sample_q     <= sample_d;
         prop_q       <= prop_d;
         deriv_q      <= deriv_d;
         integ_q      <= integ_d;
         duty_q       <= duty_d;
         adc_start_q  <= adc_start_d;
         sum_en_q     <= sum_en_d;
         duty_valid_q <= duty_valid_d;
         overrun_q    <= overrun_d;
         adc_fault_q  <= adc_fault_d;
      end
   end

   assign adc_start    = adc_start_q;
   assign sum_en       = sum_en_q;
   assign proportional = prop_q;
   assign derivative   = deriv_q;
   assign integral     = integ_q;
   assign duty         = duty_q;
   assign duty_valid   = duty_valid_q;
   assign overrun      = overrun_q;
   assign adc_fault    = adc_fault_q;

endmodule

// File: tb/tb_pid_loop_ctrl.sv
// Directed bench for pid_loop_ctrl with a 6-busy-cycle pid_sum model (unit gains or a fixed stub result).
`timescale 1ns/1ps
module tb_pid_loop_ctrl;
   localparam int W = 13;

   logic                  clk = 1'b0;
   logic                  n_rst = 1'b0;
   logic                  enable = 1'b0;
   logic                  sample_tick = 1'b0;
   logic                  adc_valid = 1'b0;
   logic [W-1:0]          setpoint = '0;
   logic [W-1:0]          adc_data = '0;
   logic                  adc_start, sum_en, duty_valid, overrun, adc_fault;
   logic signed [W-1:0]   proportional, derivative;
   logic signed [2*W-1:0] integral;
   logic                  sum_rdy;
   logic signed [3*W:0]   sum;
   logic [9:0]            duty;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   pid_loop_ctrl dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .enable       (enable),
      .sample_tick  (sample_tick),
      .setpoint     (setpoint),
      .adc_start    (adc_start),
      .adc_valid    (adc_valid),
      .adc_data     (adc_data),
      .proportional (proportional),
      .derivative   (derivative),
      .integral     (integral),
      .sum_en       (sum_en),
      .sum_rdy      (sum_rdy),
      .sum          (sum),
      .duty         (duty),
      .duty_valid   (duty_valid),
      .overrun      (overrun),
      .adc_fault    (adc_fault)
   );

   // pid_sum model: busy for 6 cycles after sum_en, result = p+d+i or a forced stub value
   int                  busy_cnt;
   logic                use_stub = 1'b0;
   logic signed [3*W:0] stub_val = '0;
   logic signed [3*W:0] model;
   assign model   = proportional + derivative + integral;
   assign sum_rdy = (busy_cnt == 0);

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         busy_cnt <= 0;
         sum      <= '0;
      end else if (sum_en) begin
         busy_cnt <= 6;
         sum      <= use_stub ? stub_val : model;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   int   n_adc_start = 0;
   int   sum_en_cyc  = 0;
   int   rdy_rise_cyc = 0;
   logic rdy_prev = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      rdy_prev <= sum_rdy;
      if (adc_start) n_adc_start <= n_adc_start + 1;
      if (sum_en) sum_en_cyc <= cyc;
      if (sum_rdy && !rdy_prev) rdy_rise_cyc <= cyc;
   end

   task automatic chk(input string tag, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Tick, wait for adc_start, return the ADC sample in the first ADC_WAIT cycle (k).
   task automatic launch(input logic [W-1:0] val, output int k);
      int t = 0;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      while (!adc_start && t < 20) begin
         step();
         t++;
      end
      chk("adc_start", adc_start, 1);
      step();
      adc_valid = 1'b1;
      adc_data  = val;
      k = cyc;
      step();
      adc_valid = 1'b0;
   endtask

   task automatic wait_duty(output int dvc);
      int t = 0;
      while (!duty_valid && t < 40) begin
         step();
         t++;
      end
      chk("duty_valid_seen", duty_valid, 1);
      dvc = cyc;
   endtask

   task automatic iter(input string tag, input logic [W-1:0] val,
                       input int ep, input int ed, input int ei, input int edty);
      int k, dvc;
      launch(val, k);
      wait_duty(dvc);
      chk({tag, ".p"}, proportional, ep);
      chk({tag, ".d"}, derivative, ed);
      chk({tag, ".i"}, integral, ei);
      chk({tag, ".duty"}, duty, edty);
      chk({tag, ".dv_after_rdy"}, dvc - rdy_rise_cyc, 1);
   endtask

   initial begin
      int k, dvc, s, t, n0;

      // reset state
      repeat (3) step();
      chk("rst.duty", duty, 0);
      chk("rst.outs", {adc_start, sum_en, duty_valid, overrun, adc_fault}, 0);
      chk("rst.pdi", {proportional, derivative, integral}, 0);
      n_rst = 1'b1;
      enable = 1'b1;
      setpoint = 13'd1000;
      step();

      // first iteration with unit-gain model: checks exact cycle timing
      launch(13'd900, k);
      wait_duty(dvc);
      chk("it1.sum_en_lat", sum_en_cyc - k, 3);
      chk("it1.dv_lat", dvc - k, 11);
      chk("it1.dv_after_rdy", dvc - rdy_rise_cyc, 1);
      chk("it1.p", proportional, 100);
      chk("it1.d", derivative, 100);
      chk("it1.i", integral, 100);
      chk("it1.duty", duty, 0);

      iter("it2", 13'd950, 50, -50, 150, 0);

      // clamp of the shifted sum
      use_stub = 1'b1;
      stub_val = 40'sd300000;
      iter("clamp_mid", 13'd950, 50, 0, 200, 292);
      stub_val = -40'sd5;
      iter("clamp_neg", 13'd950, 50, 0, 250, 0);
      stub_val = 40'sd1073741824;
      iter("clamp_hi", 13'd950, 50, 0, 300, 1023);

      // error saturation, then anti-windup at duty 0
      setpoint = 13'd0;
      stub_val = -40'sd5;
      iter("esat", 13'd8191, -4095, -4095, -3795, 0);
      for (int i = 0; i < 10; i++) iter("windup", 13'd8191, -4095, 0, -3795, 0);

      setpoint = 13'd1000;
      stub_val = 40'sd300000;
      iter("recover", 13'd900, 100, 4095, -3695, 292);

      // ADC timeout
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      t = 0;
      while (!adc_start && t < 20) begin step(); t++; end
      chk("to.adc_start", adc_start, 1);
      s = cyc;
      t = 0;
      while (!adc_fault && t < 400) begin step(); t++; end
      chk("to.fault", adc_fault, 1);
      chk("to.fault_lat", cyc - s, 256);
      chk("to.duty", duty, 292);
      chk("to.i", integral, -3695);
      step();
      chk("to.fault_pulse", adc_fault, 0);
      iter("after_to", 13'd900, 100, 0, -3595, 292);

      // overrun during SUM_WAIT, then disable mid-sum
      n0 = n_adc_start;
      launch(13'd900, k);
      repeat (4) step();
      chk("ov.busy", sum_rdy, 0);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      chk("ov.pulse", overrun, 1);
      chk("ov.no_start", n_adc_start - n0, 1);
      enable = 1'b0;
      step();
      chk("dis.duty", duty, 0);
      chk("dis.dv", duty_valid, 1);
      chk("dis.i", integral, 0);
      chk("dis.pd", {proportional, derivative}, 0);
      enable = 1'b1;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      chk("reen.overrun", overrun, 1);
      chk("reen.adc_start", adc_start, 0);
      t = 0;
      while (!sum_rdy && t < 20) begin step(); t++; end
      chk("reen.rdy", sum_rdy, 1);
      chk("reen.no_start", n_adc_start - n0, 1);
      iter("reen", 13'd900, 100, 100, 100, 292);

      // asynchronous reset in ADC_WAIT
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
      step();
      #2;
      n_rst = 1'b0;
      #1;
      chk("arst.duty", duty, 0);
      chk("arst.outs", {adc_start, sum_en, duty_valid, overrun, adc_fault}, 0);
      chk("arst.pdi", {proportional, derivative, integral}, 0);
      step();
      #2;
      n_rst = 1'b1;
      step();
      iter("post_rst", 13'd900, 100, 100, 100, 292);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
